// File: rtl/cmos_pkg.sv
// Shared definitions for the CMOS window capture block: FSM states and
// default capture window (full 640x480 VGA frame).
package cmos_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SKIP    = 2'd1,
    WAIT_VS = 2'd2,
    ACTIVE  = 2'd3
  } cmos_state_e;

  localparam int DEF_WIN_X0 = 0;
  localparam int DEF_WIN_X1 = 639;
  localparam int DEF_WIN_Y0 = 0;
  localparam int DEF_WIN_Y1 = 479;

endpackage

// File: rtl/cmos_sync_edge.sv
// Registered copies of VSYNC/HREF and single-cycle edge pulses derived from
// comparing the live input against its registered copy.
module cmos_sync_edge (
  input  logic CMOS_PCLK,
  input  logic iRST_N,
  input  logic vsync_in,
  input  logic href_in,
  output logic vsync_r,
  output logic href_r,
  output logic vs_rise,
  output logic vs_fall,
  output logic href_rise,
  output logic href_fall
);

  logic vsync_q, vsync_d;
  logic href_q, href_d;

  always_comb begin
    vsync_d = vsync_in;
    href_d  = href_in;
  end

  // VSYNC idles high, so its copy resets high to avoid a false edge.
  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      vsync_q <= 1'b1;
      href_q  <= 1'b0;
    end else begin
      vsync_q <= vsync_d;
      href_q  <= href_d;
    end
  end

  assign vsync_r   = vsync_q;
  assign href_r    = href_q;
  assign vs_rise   =  vsync_in & ~vsync_q;
  assign vs_fall   = ~vsync_in &  vsync_q;
  assign href_rise =  href_in  & ~href_q;
  assign href_fall = ~href_in  &  href_q;

endmodule

// File: rtl/cmos_window_capture.sv
// Captures CMOS sensor bytes, assembles pixels and emits only those inside a
// per-frame window. Optional frame statistics: define CMOS_FRAME_STATS_EN.
module cmos_window_capture
  import cmos_pkg::*;
#(
  parameter int BYTES_PER_PIX = 2,
  parameter int XW            = 11,
  parameter int YW            = 10,
  parameter int SKIP_FRAMES   = 10
) (
  input  logic                       CMOS_PCLK,
  input  logic                       iRST_N,
  input  logic                       init_done,
  input  logic                       CMOS_VSYNC,
  input  logic                       CMOS_HREF,
  input  logic [7:0]                 CMOS_iDATA,
  input  logic [XW-1:0]              win_x0,
  input  logic [XW-1:0]              win_x1,
  input  logic [YW-1:0]              win_y0,
  input  logic [YW-1:0]              win_y1,
  output logic [8*BYTES_PER_PIX-1:0] o_data,
  output logic                       o_valid,
  output logic                       o_sof,
  output logic                       o_eol,
`ifdef CMOS_FRAME_STATS_EN
  output logic [15:0]                o_stat_pix,
  output logic [YW-1:0]              o_stat_lines,
`endif
  output logic [7:0]                 o_frame_cnt
);

  localparam int   DW         = 8 * BYTES_PER_PIX;
  localparam logic LAST_PHASE = 1'(BYTES_PER_PIX - 1);

  logic vsync_r, href_r, vs_rise, vs_fall, href_rise, href_fall;

  cmos_sync_edge u_sync (
    .CMOS_PCLK (CMOS_PCLK),
    .iRST_N    (iRST_N),
    .vsync_in  (CMOS_VSYNC),
    .href_in   (CMOS_HREF),
    .vsync_r   (vsync_r),
    .href_r    (href_r),
    .vs_rise   (vs_rise),
    .vs_fall   (vs_fall),
    .href_rise (href_rise),
    .href_fall (href_fall)
  );

  cmos_state_e     state_q, state_d;
  logic [15:0]     skip_q, skip_d;
  logic            phase_q, phase_d;
  logic [DW-1:0]   asm_q, asm_d;
  logic [XW-1:0]   x_q, x_d;
  logic [YW-1:0]   y_q, y_d;
  logic [XW-1:0]   wx0_q, wx0_d, wx1_q, wx1_d;
  logic [YW-1:0]   wy0_q, wy0_d, wy1_q, wy1_d;
  logic            seen_q, seen_d;
  logic [DW-1:0]   data_q, data_d;
  logic            valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic [7:0]      fcnt_q, fcnt_d;

  logic            in_active, frame_start, frame_end;
  logic            byte_en, pix_done, in_win;
  logic [XW-1:0]   pix_x;
  logic [DW-1:0]   pix_word;

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Losing init_done overrides every transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (init_done) state_d = SKIP;
      SKIP:    if (SKIP_FRAMES == 0) state_d = WAIT_VS;
               else if (vs_rise && (skip_q + 16'd1) == 16'(SKIP_FRAMES)) state_d = WAIT_VS;
      WAIT_VS: if (vs_fall) state_d = ACTIVE;
      ACTIVE:  if (vs_rise) state_d = WAIT_VS;
      default: state_d = IDLE;
    endcase
    if (!init_done) state_d = IDLE;
  end

  always_comb begin
    in_active   = init_done && (state_q == ACTIVE);
    frame_start = init_done && (state_q == WAIT_VS) && vs_fall;
    frame_end   = in_active && vs_rise;
  end

  // The byte on an HREF rising edge belongs to column 0.
  always_comb begin
    byte_en  = in_active && CMOS_HREF && !vsync_r;
    pix_done = byte_en && (phase_q == LAST_PHASE);
    pix_x    = href_r ? x_q : '0;
    pix_word = DW'({asm_q, CMOS_iDATA});
    in_win   = (pix_x >= wx0_q) && (pix_x <= wx1_q) && (y_q >= wy0_q) && (y_q <= wy1_q);
  end

  always_comb begin
    skip_d  = skip_q;
    phase_d = phase_q;
    asm_d   = asm_q;
    x_d     = x_q;
    y_d     = y_q;
    wx0_d   = wx0_q;
    wx1_d   = wx1_q;
    wy0_d   = wy0_q;
    wy1_d   = wy1_q;
    seen_d  = seen_q;
    data_d  = data_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eol_d   = 1'b0;
    fcnt_d  = fcnt_q;
    if (vs_fall) begin
      wx0_d = win_x0;
      wx1_d = win_x1;
      wy0_d = win_y0;
      wy1_d = win_y1;
    end
    if (!init_done) begin
      skip_d  = '0;
      phase_d = 1'b0;
      x_d     = '0;
      y_d     = '0;
      seen_d  = 1'b0;
    end else begin
      if (state_q == IDLE) skip_d = '0;
      if (state_q == SKIP && vs_rise) skip_d = skip_q + 16'd1;
      if (frame_start) begin
        phase_d = 1'b0;
        x_d     = '0;
        y_d     = '0;
        seen_d  = 1'b0;
      end
      if (in_active) begin
        if (href_rise) x_d = '0;
        if (!CMOS_HREF) phase_d = 1'b0;
        if (byte_en) begin
          asm_d   = pix_word;
          phase_d = pix_done ? 1'b0 : phase_q + 1'b1;
        end
        if (pix_done) begin
          x_d = (pix_x != {XW{1'b1}}) ? pix_x + XW'(1) : pix_x;
          if (in_win) begin
            valid_d = 1'b1;
            data_d  = pix_word;
            sof_d   = !seen_q;
            eol_d   = (pix_x == wx1_q);
            seen_d  = 1'b1;
          end
        end
        if (href_fall && y_q != {YW{1'b1}}) y_d = y_q + YW'(1);
        if (frame_end && seen_q) fcnt_d = fcnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      skip_q  <= '0;
      phase_q <= 1'b0;
      asm_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      wx0_q   <= XW'(DEF_WIN_X0);
      wx1_q   <= XW'(DEF_WIN_X1);
      wy0_q   <= YW'(DEF_WIN_Y0);
      wy1_q   <= YW'(DEF_WIN_Y1);
      seen_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eol_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      skip_q  <= skip_d;
      phase_q <= phase_d;
      asm_q   <= asm_d;
      x_q     <= x_d;
      y_q     <= y_d;
      wx0_q   <= wx0_d;
      wx1_q   <= wx1_d;
      wy0_q   <= wy0_d;
      wy1_q   <= wy1_d;
      seen_q  <= seen_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eol_q   <= eol_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_sof       = sof_q;
  assign o_eol       = eol_q;
  assign o_frame_cnt = fcnt_q;

`ifdef CMOS_FRAME_STATS_EN
  logic [15:0]   pcnt_q, pcnt_d, spix_q, spix_d;
  logic [YW-1:0] slines_q, slines_d;

  // The line counter at frame end equals the number of lines in the frame.
  always_comb begin
    pcnt_d   = pcnt_q;
    spix_d   = spix_q;
    slines_d = slines_q;
    if (!init_done || frame_start) pcnt_d = '0;
    else if (pix_done && in_win && pcnt_q != 16'hFFFF) pcnt_d = pcnt_q + 16'd1;
    if (frame_end) begin
      spix_d   = pcnt_q;
      slines_d = y_q;
    end
  end

  always_ff @(posedge CMOS_PCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      pcnt_q   <= '0;
      spix_q   <= '0;
      slines_q <= '0;
    end else begin
      pcnt_q   <= pcnt_d;
      spix_q   <= spix_d;
      slines_q <= slines_d;
    end
  end

  assign o_stat_pix   = spix_q;
  assign o_stat_lines = slines_q;
`endif

endmodule

// File: doc/cmos_window_capture.md
CMOS_WINDOW_CAPTURE -- requirements
Module: cmos_window_capture

Interface
REQ-001 Parameter BYTES_PER_PIX, default 2, bytes per pixel (legal values 1 or 2).
REQ-002 Parameter XW, default 11, width of column counter and window X bounds.
REQ-003 Parameter YW, default 10, width of line counter and window Y bounds.
REQ-004 Parameter SKIP_FRAMES, default 10, complete frames discarded after init_done (0 legal).
REQ-005 Port CMOS_PCLK  in  1  pixel clock; all logic on its rising edge.
REQ-006 Port iRST_N  in  1  reset, asynchronous, active-low.
REQ-007 Port init_done  in  1  sensor SCCB configuration complete.
REQ-008 Port CMOS_VSYNC  in  1  frame sync; low = frame active.
REQ-009 Port CMOS_HREF  in  1  line valid; high = byte valid.
REQ-010 Port CMOS_iDATA  in  8  sensor byte.
REQ-011 Ports win_x0, win_x1  in  XW  inclusive pixel-column window bounds.
REQ-012 Ports win_y0, win_y1  in  YW  inclusive line window bounds.
REQ-013 Port o_data  out  8*BYTES_PER_PIX  assembled pixel, first byte in MSBs.
REQ-014 Ports o_valid, o_sof, o_eol  out  1 each  pixel strobe, first windowed pixel of frame, last windowed pixel of line.
REQ-015 Port o_frame_cnt  out  8  frames delivered since reset.

Function
REQ-016 FSM states IDLE, SKIP, WAIT_VS, ACTIVE; IDLE->SKIP when init_done=1.
REQ-017 SKIP: count VSYNC rising edges; after SKIP_FRAMES edges go to WAIT_VS (SKIP_FRAMES=0: straight to WAIT_VS).
REQ-018 WAIT_VS->ACTIVE on VSYNC falling edge; ACTIVE->WAIT_VS on VSYNC rising edge.
REQ-019 init_done=0 in any state forces IDLE next cycle, clears counters, aborts the current frame; o_frame_cnt is not cleared.
REQ-020 Edges are detected against a 1-cycle registered copy of VSYNC, reset value 1.
REQ-021 In ACTIVE with HREF=1, bytes are assembled per BYTES_PER_PIX; pixel completes on the last byte.
REQ-022 HREF falling mid-pixel discards the partial pixel; byte phase restarts at 0 on the next line.
REQ-023 Column counter x is reset to 0 on each HREF rising edge and increments per completed pixel, saturating at 2^XW-1.
REQ-024 Line counter y is reset to 0 at frame start and increments on each HREF falling edge, saturating at 2^YW-1.
REQ-025 Window bounds are sampled on the VSYNC falling edge; input changes mid-frame do not take effect until the next frame.
REQ-026 A completed pixel is in-window when x0<=x<=x1 and y0<=y<=y1; x0>x1 or y0>y1 yields no output for the frame.
REQ-027 o_valid is high for exactly one cycle, on the cycle after the last byte of an in-window pixel is sampled; o_data holds that pixel until the next o_valid.
REQ-028 o_sof is high with o_valid on the first in-window pixel of a frame only.
REQ-029 o_eol is high with o_valid when x==win_x1.
REQ-030 o_frame_cnt increments modulo 256 on each VSYNC rising edge that ends a frame in ACTIVE with at least one o_valid.

Reset
REQ-031 On iRST_N low: FSM=IDLE, all counters=0, o_data=0, o_valid=o_sof=o_eol=0, o_frame_cnt=0, registered VSYNC=1.
REQ-032 Reset asserted mid-frame takes effect immediately; after release, capture resumes only via IDLE and SKIP.

Configuration
REQ-033 Macro CMOS_FRAME_STATS_EN adds outputs o_stat_pix (16 bits) and o_stat_lines (YW bits).
REQ-034 With the macro defined, the outputs latch the in-window pixel count and the line count on each frame-ending VSYNC rising edge; the pixel count saturates at 16'hFFFF, and both reset to 0.
REQ-035 Without the macro, neither the ports nor the statistics logic exist; all other behaviour is identical.

Structure
REQ-036 Shared package cmos_pkg holds the FSM state enumeration and the default window constants (640x480 VGA).
REQ-037 Sub-module cmos_sync_edge provides the registered VSYNC/HREF and their rise/fall pulses; everything else is in the top.

Verification
REQ-038 BYTES_PER_PIX=2, SKIP_FRAMES=0, window 0..3/0..1, 4x2 frame with bytes 0x12,0x34,... -> first o_data=0x1234 with o_sof=1; 8 o_valid total; o_eol on x=3; o_frame_cnt=1.
REQ-039 SKIP_FRAMES=2, three frames -> no o_valid in frames 1-2; frame 3 is delivered; o_frame_cnt=1.
REQ-040 Window x 2..3, y 1..1 on an 8x4 frame -> exactly 2 o_valid (x=2,3, line 1); o_sof on x=2.
REQ-041 HREF dropped after the first byte of a pixel -> no o_valid for it; the next line's first pixel is assembled correctly.
REQ-042 win_x0=5, win_x1=2 -> zero o_valid; o_frame_cnt unchanged. Window changed mid-frame -> applies from the next frame.
REQ-043 init_done deasserted mid-frame, then iRST_N pulsed mid-frame -> o_valid=0 next cycle, FSM=IDLE, outputs at reset values; with CMOS_FRAME_STATS_EN, a 4x2 frame gives o_stat_pix=8, o_stat_lines=2.
